// File: rtl/gpr_mp.sv
// gpr_mp -- multi-read-port general purpose register file with two write
// ports and an optional load scoreboard.
//
// Optional feature: define GPR_MP_SCOREBOARD_EN to build the pending-load
// scoreboard. Without it, busy_o and pend_cnt_o are tied to 0 and
// sb_set_i / sb_addr_i are ignored.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   we_a_i/waddr_a_i/wdata_a_i     write port A (main writeback, wins collisions)
//   we_b_i/waddr_b_i/wdata_b_i     write port B (late-load writeback)
//   raddr_i  [NRD*AW]              packed read addresses, port k at [k*AW +: AW]
//   rdata_o  [NRD*DW]              packed read data with same-cycle bypass
//   sb_set_i/sb_addr_i             mark a register pending a port-B write
//   busy_o   [NRD]                 registered pending bit at each read address
//   pend_cnt_o [AW+1]              registered count of pending registers
module gpr_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int X0_ZERO = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_a_i,
  input  logic [AW-1:0]      waddr_a_i,
  input  logic [DW-1:0]      wdata_a_i,
  input  logic               we_b_i,
  input  logic [AW-1:0]      waddr_b_i,
  input  logic [DW-1:0]      wdata_b_i,
  input  logic [NRD*AW-1:0]  raddr_i,
  output logic [NRD*DW-1:0]  rdata_o,
  input  logic               sb_set_i,
  input  logic [AW-1:0]      sb_addr_i,
  output logic [NRD-1:0]     busy_o,
  output logic [AW:0]        pend_cnt_o
);

  localparam int DEPTH = 2**AW;
  localparam bit X0    = (X0_ZERO != 0);

  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] regs_d [DEPTH];

  logic wr_a_ok, wr_b_ok;
  assign wr_a_ok = we_a_i && !(X0 && waddr_a_i == '0);
  assign wr_b_ok = we_b_i && !(X0 && waddr_b_i == '0);

  // Port A applied last so it wins an address collision with port B.
  always_comb begin
    regs_d = regs_q;
    if (wr_b_ok) regs_d[waddr_b_i] = wdata_b_i;
    if (wr_a_ok) regs_d[waddr_a_i] = wdata_a_i;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

`ifdef GPR_MP_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  // Clear before set: a simultaneous set marks a new load, so the bit stays set.
  always_comb begin
    pend_d = pend_q;
    if (we_b_i) pend_d[waddr_b_i] = 1'b0;
    if (sb_set_i && !(X0 && sb_addr_i == '0)) pend_d[sb_addr_i] = 1'b1;
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;
`else
  logic unused_sb;
  assign unused_sb  = ^{sb_set_i, sb_addr_i};
  assign busy_o     = '0;
  assign pend_cnt_o = '0;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    assign ra = raddr_i[k*AW +: AW];

    // Hardwired zero beats bypass; port A bypass beats port B.
    always_comb begin
      rd = regs_q[ra];
      if (X0 && ra == '0)                   rd = '0;
      else if (we_a_i && waddr_a_i == ra)   rd = wdata_a_i;
      else if (we_b_i && waddr_b_i == ra)   rd = wdata_b_i;
    end

    assign rdata_o[k*DW +: DW] = rd;
`ifdef GPR_MP_SCOREBOARD_EN
    assign busy_o[k] = pend_q[ra];
`endif
  end

endmodule

// File: tb/tb_gpr_mp.sv
module tb_gpr_mp;

`ifdef GPR_MP_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_a = 1'b0, we_b = 1'b0, sb_set = 1'b0;
  logic [4:0]  waddr_a = '0, waddr_b = '0, sb_addr = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic [1:0]  busy;
  logic [5:0]  pend_cnt;

  int n_pass = 0, n_total = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  gpr_mp dut (
    .clk(clk), .rst(rst),
    .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
    .we_b_i(we_b), .waddr_b_i(waddr_b), .wdata_b_i(wdata_b),
    .raddr_i(raddr), .rdata_o(rdata),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr),
    .busy_o(busy), .pend_cnt_o(pend_cnt)
  );

  // Reference model: register contents and pending flags as plain arrays.
  logic [31:0] m_mem  [32];
  bit          m_pend [32];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we_b && waddr_b != 0) m_mem[waddr_b] = wdata_b;
      if (we_a && waddr_a != 0) m_mem[waddr_a] = wdata_a;
      if (SB) begin
        if (we_b) m_pend[waddr_b] = 1'b0;
        if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we_a && waddr_a == a) return wdata_a;
    if (we_b && waddr_b == a) return wdata_b;
    return m_mem[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    foreach (m_pend[i]) if (m_pend[i]) c++;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_rdata%0d", k), rdata[k*32 +: 32], exp_rd(raddr[k*5 +: 5]));
        chk($sformatf("model_busy%0d", k), {31'b0, busy[k]},
            {31'b0, SB ? m_pend[raddr[k*5 +: 5]] : 1'b0});
      end
      chk("model_pend_cnt", {26'b0, pend_cnt}, exp_cnt());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; sb_set = 0; rst = 0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      we_a    = 1'($urandom_range(0, 1));
      waddr_a = 5'($urandom);
      wdata_a = $urandom;
      we_b    = 1'($urandom_range(0, 1));
      waddr_b = 5'($urandom);
      wdata_b = $urandom;
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = 5'($urandom);
      raddr   = 10'($urandom);
      tick();
    end
    idle();
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    check_en = 1'b1;

    // Random traffic, then reset with a concurrent write and set (reset wins).
    rand_cycles(40);
    rst = 1; we_a = 1; waddr_a = 5'd6; wdata_a = 32'h1234; sb_set = 1; sb_addr = 5'd4;
    tick();
    idle();
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      @(negedge clk);
      chk("rst_rd0", rdata[31:0], 32'h0);
      chk("rst_rd1", rdata[63:32], 32'h0);
      chk("rst_busy", {30'b0, busy}, 32'h0);
      chk("rst_cnt", {26'b0, pend_cnt}, 32'h0);
      tick();
    end

    // Port A bypass.
    we_a = 1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    @(negedge clk); chk("byp_same", rdata[31:0], 32'hDEADBEEF);
    tick(); idle();
    @(negedge clk); chk("byp_after", rdata[31:0], 32'hDEADBEEF);
    tick();

    // A/B collision, plus a port-B-only bypass on read port 1.
    we_a = 1; waddr_a = 5'd7; wdata_a = 32'h11;
    we_b = 1; waddr_b = 5'd7; wdata_b = 32'h22;
    raddr = {5'd5, 5'd7};
    @(negedge clk); chk("coll_same", rdata[31:0], 32'h11);
    tick(); idle();
    @(negedge clk); chk("coll_stored", rdata[31:0], 32'h11);
    tick();
    we_b = 1; waddr_b = 5'd12; wdata_b = 32'h55; raddr = {5'd12, 5'd7};
    @(negedge clk); chk("bypb_same", rdata[63:32], 32'h55);
    tick(); idle();

    // Register zero is immune to writes, bypass and scoreboard sets.
    we_a = 1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; sb_set = 1; sb_addr = 5'd0;
    raddr = {5'd0, 5'd0};
    @(negedge clk); chk("x0_same", rdata[31:0], 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("x0_after", rdata[31:0], 32'h0);
    chk("x0_busy", {30'b0, busy}, 32'h0);
    chk("x0_cnt", {26'b0, pend_cnt}, 32'h0);
    tick();

    // Scoreboard sequence.
    sb_set = 1; sb_addr = 5'd3; tick();
    sb_addr = 5'd9; tick(); idle();
    raddr = {5'd9, 5'd3};
    @(negedge clk);
    chk("sb_cnt2", {26'b0, pend_cnt}, SB ? 32'd2 : 32'd0);
    chk("sb_busy", {30'b0, busy}, SB ? 32'd3 : 32'd0);
    tick();
    sb_set = 1; sb_addr = 5'd9; we_b = 1; waddr_b = 5'd9; wdata_b = 32'hABCD;
    raddr = {5'd3, 5'd9};
    @(negedge clk); chk("sb_same_busy", {31'b0, busy[0]}, {31'b0, SB});
    tick(); idle();
    @(negedge clk);
    chk("sb_keep_busy", {31'b0, busy[0]}, {31'b0, SB});
    chk("sb_reg9", rdata[31:0], 32'hABCD);
    chk("sb_cnt_keep", {26'b0, pend_cnt}, SB ? 32'd2 : 32'd0);
    tick();
    we_b = 1; waddr_b = 5'd3; wdata_b = 32'h33; tick(); idle();
    @(negedge clk);
    chk("sb_cnt1", {26'b0, pend_cnt}, SB ? 32'd1 : 32'd0);
    chk("sb_busy3_clr", {31'b0, busy[1]}, 32'd0);
    tick();
    // Re-setting a pending bit leaves the count alone.
    sb_set = 1; sb_addr = 5'd9; tick(); idle();
    @(negedge clk); chk("sb_reset_same", {26'b0, pend_cnt}, SB ? 32'd1 : 32'd0);
    tick();

    // Reset beats a same-cycle set.
    rst = 1; sb_set = 1; sb_addr = 5'd4; tick(); idle();
    raddr = {5'd4, 5'd4};
    @(negedge clk);
    chk("rstp_cnt", {26'b0, pend_cnt}, 32'd0);
    chk("rstp_busy", {30'b0, busy}, 32'd0);
    tick();

    rand_cycles(300);
    tick();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
